rob_param: RTL and testbench
============================

// Module: rob_param
// PURPOSE
//  Parametrised circular reorder buffer. Allocates entries in program order at dispatch and
//  captures CDB results out of order. Retires the head in order to the regfile or data memory.
//  Flushes all entries when a mispredicted branch retires.
//  Sits between decode/dispatch, the reservation stations and CDB, and the regfile/dmem port.
// PARAMETERS
//  DEPTH   8                entries; power of two, >=2
//  TAG_W   $clog2(DEPTH)    ROB tag width
//  ARCH_W  5                architectural register index width
//  DATA_W  32               result / PC width
// PORTS
//  clk            in   1       clock; all state on posedge
//  reset          in   1       async, active-high; clears all state
//  alloc_valid    in   1       dispatch requests an entry
//  alloc_is_store in   1       entry is a store (no rd write)
//  alloc_is_br    in   1       entry is a branch/jump
//  alloc_rd       in   ARCH_W  destination register (x0 => no regfile write)
//  alloc_ready    out  1       entry available (count != DEPTH)
//  alloc_tag      out  TAG_W   tag given to this cycle's allocation (= tail index)
//  cdb_valid      in   1       result broadcast
//  cdb_tag        in   TAG_W   entry being completed
//  cdb_data       in   DATA_W  result value (store: ignored)
//  cdb_mispred    in   1       branch resolved mispredicted
//  cdb_target     in   DATA_W  correct PC for the mispredict
//  entry_ready    out  DEPTH   per-entry valid&done vector (operand forwarding)
//  commit_valid   out  1       head retiring this cycle
//  commit_rd      out  ARCH_W  regfile index; regfile_load = commit_valid & rd!=0 & !store
//  commit_data    out  DATA_W  regfile write data
//  commit_tag     out  TAG_W   retiring tag (regfile clears in-flight if tag matches)
//  st_commit      out  1       request to perform head store in dmem
//  data_mem_resp  in   1       dmem completed the store
//  flush          out  1       one-cycle pulse: squash pipeline
//  flush_pc       out  DATA_W  redirect PC, valid with flush
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all valid/done/mispred=0, FSM=RUN. All outputs 0 except
//    alloc_ready=1.
//  - Pointers are TAG_W+1 bits; the MSB is the wrap bit. full = (head^tail)==DEPTH, empty = head==tail.
//  - Alloc: alloc_valid&alloc_ready writes entry[tail] (valid=1, done=0) and increments tail.
//    alloc_tag = tail[TAG_W-1:0], combinational.
//  - alloc_ready is from registered count only. When full, a same-cycle retire does not admit an alloc.
//  - CDB: writes data/mispred/target and sets done for entry[cdb_tag] only if it is valid.
//    A CDB write to an invalid entry is dropped. Writes are visible in entry_ready next cycle.
//  - Earliest retire is the cycle after the CDB write; there is no same-cycle CDB->commit bypass.
//  - FSM RUN: the head is valid&done&!store&!mispred -> commit_valid=1, head++ (1 per cycle).
//    The head is a valid&done store -> go to ST_WAIT; st_commit=1 while in ST_WAIT.
//    The head is valid&done&mispred -> commit_valid=1 (link reg write allowed), flush=1,
//    flush_pc=target; next edge clears all valid bits, head=tail=0, count=0.
//  - FSM ST_WAIT: hold st_commit=1 until data_mem_resp. In that cycle commit_valid=1 and head++,
//    then return to RUN. The store gets no regfile write.
//  - Alloc in the flush cycle is discarded; alloc_ready=0 during flush.
//  - A CDB write in the flush cycle is discarded.
//  - Simultaneous alloc and retire: count unchanged, both pointers advance.
//  - Reset mid-ST_WAIT: returns to RUN, st_commit drops asynchronously, and the entry is lost.
// CONFIGURATION
//  ROB_STATS_EN defined: adds ports stat_commits (out, 32) and stat_flushes (out, 16).
//    Both are saturating counters, reset to 0.
//    stat_commits counts every commit_valid cycle; stat_flushes counts every flush pulse.
//  ROB_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1) Reset, alloc 3 entries (rd=1,2,3), CDB tags 2,0,1 data A,B,C -> commits in order
//     rd1=B, rd2=C, rd3=A, one per cycle, on the cycles after each head becomes done.
//  2) Alloc 8 with DEPTH=8 -> alloc_ready=0. Complete and retire tag0 -> next alloc gets tag0
//     and the wrap bit toggles.
//  3) Store at the head done -> st_commit=1 for 4 cycles. data_mem_resp on cycle 4 -> retires,
//     commit_rd write suppressed.
//  4) Branch tag1 mispred target 0x60 with tags 2-5 valid -> flush=1 and flush_pc=0x60 for 1 cycle.
//     Next cycle count=0, entry_ready=0, alloc_tag=0.
//  5) CDB to a free tag 6 while empty -> no state change; entry_ready stays 0.
//  6) With ROB_STATS_EN: run tests 1+4 -> stat_commits=5 (3 plus tag0 and branch tag1), stat_flushes=1.

Source files
------------

// File: rtl/rob_param.sv
// rob_param: circular reorder buffer with in-order retire, store/dmem handshake and mispredict flush.
// Define ROB_STATS_EN to add saturating stat_commits / stat_flushes counters.
module rob_param #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int ARCH_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic              alloc_is_store,
  input  logic              alloc_is_br,
  input  logic [ARCH_W-1:0] alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispred,
  input  logic [DATA_W-1:0] cdb_target,
  output logic [DEPTH-1:0]  entry_ready,
  output logic              commit_valid,
  output logic [ARCH_W-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              st_commit,
  input  logic              data_mem_resp,
`ifdef ROB_STATS_EN
  output logic [31:0]       stat_commits,
  output logic [15:0]       stat_flushes,
`endif
  output logic              flush,
  output logic [DATA_W-1:0] flush_pc
);

  localparam logic [TAG_W:0] PTR_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [TAG_W:0]    head_q, tail_q, count_q;
  logic [DEPTH-1:0]  valid_q, done_q, mispred_q, store_q, br_q;
  logic [ARCH_W-1:0] rd_q     [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] target_q [DEPTH];

  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic              empty, head_ready, head_store;
  logic              alloc_fire, cdb_fire, retire;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  assign empty      = (head_q == tail_q);
  assign head_ready = !empty && valid_q[head_idx] && done_q[head_idx];
  assign head_store = store_q[head_idx];

  // Retire decision: stores detour through ST_WAIT, a mispredicted branch retires and flushes.
  always_comb begin
    state_d      = state_q;
    commit_valid = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    case (state_q)
      RUN: begin
        if (head_ready) begin
          if (head_store) begin
            state_d = ST_WAIT;
          end else begin
            commit_valid = 1'b1;
            if (mispred_q[head_idx]) begin
              flush    = 1'b1;
              flush_pc = target_q[head_idx];
            end
          end
        end
      end
      ST_WAIT: begin
        if (data_mem_resp) begin
          commit_valid = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign alloc_ready = (count_q != CNT_FULL) && !flush;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign cdb_fire    = cdb_valid && valid_q[cdb_tag] && !flush;
  assign retire      = commit_valid && !flush;

  assign commit_rd   = (commit_valid && !head_store) ? rd_q[head_idx]   : '0;
  assign commit_data = (commit_valid && !head_store) ? data_q[head_idx] : '0;
  assign commit_tag  = commit_valid ? head_idx : '0;
  assign st_commit   = (state_q == ST_WAIT);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
    assign entry_ready[gi] = valid_q[gi] & done_q[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      state_q <= state_d;
      if (retire)     head_q <= head_q + PTR_ONE;
      if (alloc_fire) tail_q <= tail_q + PTR_ONE;
      case ({alloc_fire, retire})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Alloc never targets the retiring head (no alloc while full), so the updates don't collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      store_q   <= '0;
      br_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]     <= '0;
        data_q[i]   <= '0;
        target_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (retire) valid_q[head_idx] <= 1'b0;
      if (alloc_fire) begin
        valid_q[tail_idx]   <= 1'b1;
        done_q[tail_idx]    <= 1'b0;
        mispred_q[tail_idx] <= 1'b0;
        store_q[tail_idx]   <= alloc_is_store;
        br_q[tail_idx]      <= alloc_is_br;
        rd_q[tail_idx]      <= alloc_rd;
      end
      if (cdb_fire) begin
        done_q[cdb_tag]    <= 1'b1;
        mispred_q[cdb_tag] <= cdb_mispred & br_q[cdb_tag];
        target_q[cdb_tag]  <= cdb_target;
        if (!store_q[cdb_tag]) data_q[cdb_tag] <= cdb_data;
      end
    end
  end

`ifdef ROB_STATS_EN
  logic [31:0] stat_commits_q;
  logic [15:0] stat_flushes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_commits_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (commit_valid && (stat_commits_q != '1)) stat_commits_q <= stat_commits_q + 32'd1;
      if (flush && (stat_flushes_q != '1))        stat_flushes_q <= stat_flushes_q + 16'd1;
    end
  end

  assign stat_commits = stat_commits_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed scenarios plus randomized traffic against a program-order queue model.
// Build with ROB_STATS_EN defined to also check the statistics counters.
module tb_rob_param;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int ARCH_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alloc_valid = 1'b0, alloc_is_store = 1'b0, alloc_is_br = 1'b0;
  logic [ARCH_W-1:0] alloc_rd = '0;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid = 1'b0, cdb_mispred = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0, cdb_target = '0;
  logic [DEPTH-1:0]  entry_ready;
  logic              commit_valid;
  logic [ARCH_W-1:0] commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic              st_commit;
  logic              data_mem_resp = 1'b0;
  logic              flush;
  logic [DATA_W-1:0] flush_pc;
`ifdef ROB_STATS_EN
  logic [31:0]       stat_commits;
  logic [15:0]       stat_flushes;
`endif

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ARCH_W(ARCH_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store), .alloc_is_br(alloc_is_br),
    .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
    .entry_ready(entry_ready), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag), .st_commit(st_commit),
    .data_mem_resp(data_mem_resp),
`ifdef ROB_STATS_EN
    .stat_commits(stat_commits), .stat_flushes(stat_flushes),
`endif
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  // Staged stimulus, applied to the DUT at the next falling edge.
  logic        s_av, s_st, s_br, s_cv, s_cmp, s_resp;
  logic [4:0]  s_rd;
  logic [2:0]  s_ctag;
  logic [31:0] s_cdata, s_ctgt;

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          st;
    bit          br;
    bit          done;
    bit          mp;
    logic [31:0] data;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } log_t;

  ent_t rob[$];
  log_t clog[$];
  int   m_tail;
  bit   m_wait;
  int   m_commits, m_flushes;
  int   n_tests = 0, n_fail = 0, cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  task automatic idle();
    s_av = 0; s_st = 0; s_br = 0; s_cv = 0; s_cmp = 0; s_resp = 0;
    s_rd = '0; s_ctag = '0; s_cdata = '0; s_ctgt = '0;
  endtask

  task automatic model_reset();
    rob.delete();
    m_tail = 0; m_wait = 0; m_commits = 0; m_flushes = 0;
  endtask

  // One clock cycle: drive, compare against the queue model, then advance the model.
  task automatic step();
    logic [7:0]  e_er;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_fpc;
    int          e_tag;
    bit          e_cv, e_fl, e_st, e_ar, go_wait;
    ent_t        e;
    @(negedge clk);
    alloc_valid = s_av; alloc_is_store = s_st; alloc_is_br = s_br; alloc_rd = s_rd;
    cdb_valid = s_cv; cdb_tag = s_ctag; cdb_data = s_cdata; cdb_mispred = s_cmp;
    cdb_target = s_ctgt; data_mem_resp = s_resp;
    #1;
    e_er = '0;
    foreach (rob[i]) if (rob[i].done) e_er[rob[i].tag] = 1'b1;
    e_cv = 0; e_fl = 0; e_st = 0; go_wait = 0; e_fpc = '0;
    e_rd = '0; e_data = '0; e_tag = 0;
    if (rob.size() > 0 && rob[0].done) begin
      if (m_wait) begin
        e_st = 1;
        e_cv = s_resp;
      end else if (rob[0].st) begin
        go_wait = 1;
      end else begin
        e_cv = 1;
        if (rob[0].mp) begin
          e_fl  = 1;
          e_fpc = rob[0].tgt;
        end
      end
    end
    if (e_cv) begin
      e_tag = rob[0].tag;
      if (!rob[0].st) begin
        e_rd   = rob[0].rd;
        e_data = rob[0].data;
      end
    end
    e_ar = (rob.size() < DEPTH) && !e_fl;

    chk("alloc_ready", 64'(alloc_ready), 64'(e_ar));
    chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    chk("entry_ready", 64'(entry_ready), 64'(e_er));
    chk("commit_valid", 64'(commit_valid), 64'(e_cv));
    chk("commit_rd", 64'(commit_rd), 64'(e_rd));
    chk("commit_data", 64'(commit_data), 64'(e_data));
    chk("commit_tag", 64'(commit_tag), 64'(e_tag));
    chk("st_commit", 64'(st_commit), 64'(e_st));
    chk("flush", 64'(flush), 64'(e_fl));
    chk("flush_pc", 64'(flush_pc), 64'(e_fpc));

    if (commit_valid) begin
      clog.push_back('{cyc, commit_rd, commit_data});
      $display("[TB] cyc=%0d commit tag=%0d rd=%0d data=%08h flush=%0b pc=%08h",
               cyc, commit_tag, commit_rd, commit_data, flush, flush_pc);
    end

    if (e_cv) m_commits++;
    if (e_fl) m_flushes++;
    if (e_fl) begin
      rob.delete();
      m_tail = 0;
      m_wait = 0;
    end else begin
      if (s_cv) begin
        foreach (rob[i]) begin
          if (rob[i].tag == int'(s_ctag)) begin
            e = rob[i];
            e.done = 1;
            e.mp   = s_cmp & e.br;
            e.tgt  = s_ctgt;
            if (!e.st) e.data = s_cdata;
            rob[i] = e;
          end
        end
      end
      if (s_av && e_ar) begin
        rob.push_back('{m_tail, s_rd, s_st, s_br, 1'b0, 1'b0, 32'h0, 32'h0});
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (e_cv) begin
        rob.delete(0);
        m_wait = 0;
      end else if (go_wait) begin
        m_wait = 1;
      end
    end
`ifdef ROB_STATS_EN
    @(posedge clk);
    #1;
    chk("stat_commits", 64'(stat_commits), 64'(m_commits));
    chk("stat_flushes", 64'(stat_flushes), 64'(m_flushes));
`endif
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    alloc_valid = 0; alloc_is_store = 0; alloc_is_br = 0; alloc_rd = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; cdb_mispred = 0; cdb_target = '0;
    data_mem_resp = 0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_entry_ready", 64'(entry_ready), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_st_commit", 64'(st_commit), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_flush_pc", 64'(flush_pc), 64'd0);
    reset = 1'b0;
  endtask

  task automatic alloc_one(input logic [4:0] rd, input bit st, input bit br);
    s_av = 1; s_rd = rd; s_st = st; s_br = br;
    step();
    s_av = 0; s_st = 0; s_br = 0;
  endtask

  task automatic cdb_one(input int tag, input logic [31:0] data, input bit mp, input logic [31:0] tgt);
    s_cv = 1; s_ctag = 3'(tag); s_cdata = data; s_cmp = mp; s_ctgt = tgt;
    step();
    s_cv = 0; s_cmp = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cb;
    idle();
    do_reset();

    // Out-of-order completion, in-order retire.
    clog.delete();
    alloc_one(5'd1, 0, 0);
    alloc_one(5'd2, 0, 0);
    alloc_one(5'd3, 0, 0);
    cdb_one(2, 32'hAAAA_0001, 0, 0);
    cb = cyc;
    cdb_one(0, 32'hBBBB_0002, 0, 0);
    cdb_one(1, 32'hCCCC_0003, 0, 0);
    repeat (3) step();
    chk("t1_ncommit", 64'(clog.size()), 64'd3);
    if (clog.size() == 3) begin
      chk("t1_rd0", 64'(clog[0].rd), 64'd1);
      chk("t1_d0", 64'(clog[0].data), 64'hBBBB_0002);
      chk("t1_rd1", 64'(clog[1].rd), 64'd2);
      chk("t1_d1", 64'(clog[1].data), 64'hCCCC_0003);
      chk("t1_rd2", 64'(clog[2].rd), 64'd3);
      chk("t1_d2", 64'(clog[2].data), 64'hAAAA_0001);
      chk("t1_first_cyc", 64'(clog[0].cyc), 64'(cb + 1));
      chk("t1_back2back", 64'(clog[2].cyc - clog[0].cyc), 64'd2);
    end

    // Full buffer and pointer wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc_one(5'(i + 1), 0, 0);
    s_av = 1; s_rd = 5'd20;
    step();
    chk("t2_full_ready", 64'(alloc_ready), 64'd0);
    s_av = 0;
    cdb_one(0, 32'h0000_1234, 0, 0);
    s_av = 1;
    step();
    chk("t2_retire_full_ready", 64'(alloc_ready), 64'd0);
    chk("t2_retire_valid", 64'(commit_valid), 64'd1);
    step();
    chk("t2_wrap_ready", 64'(alloc_ready), 64'd1);
    chk("t2_wrap_tag", 64'(alloc_tag), 64'd0);
    s_av = 0;
    step();
    chk("t2_after_wrap_ready", 64'(alloc_ready), 64'd0);

    // Store waits for the memory response.
    do_reset();
    alloc_one(5'd7, 1, 0);
    cdb_one(0, 32'hDEAD_BEEF, 0, 0);
    step();
    chk("t3_st_pre", 64'(st_commit), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      s_resp = (k == 4);
      step();
      chk("t3_st_hold", 64'(st_commit), 64'd1);
      chk("t3_commit_valid", 64'(commit_valid), 64'(k == 4));
      if (k == 4) chk("t3_commit_rd", 64'(commit_rd), 64'd0);
    end
    s_resp = 0;
    step();
    chk("t3_st_done", 64'(st_commit), 64'd0);

    // Reset while waiting on a store.
    do_reset();
    alloc_one(5'd9, 1, 0);
    cdb_one(0, 32'h1, 0, 0);
    step();
    step();
    chk("t3b_st_waiting", 64'(st_commit), 64'd1);
    reset = 1'b1;
    #1;
    chk("t3b_st_async_drop", 64'(st_commit), 64'd0);
    do_reset();
    step();
    chk("t3b_lost_ready", 64'(entry_ready), 64'd0);

    // Mispredicted branch flushes younger entries.
    do_reset();
    for (int i = 0; i < 6; i++) alloc_one(5'(i + 10), 0, (i == 1));
    cdb_one(1, 32'h0000_0044, 1, 32'h0000_0060);
    cdb_one(3, 32'h0000_0333, 0, 0);
    cdb_one(0, 32'h0000_0100, 0, 0);
    step();
    chk("t4_commit_tag0", 64'(commit_tag), 64'd0);
    s_av = 1; s_rd = 5'd30;
    s_cv = 1; s_ctag = 3'd4; s_cdata = 32'h55;
    step();
    chk("t4_flush", 64'(flush), 64'd1);
    chk("t4_flush_pc", 64'(flush_pc), 64'h60);
    chk("t4_flush_ready", 64'(alloc_ready), 64'd0);
    chk("t4_link_rd", 64'(commit_rd), 64'd11);
    chk("t4_link_data", 64'(commit_data), 64'h44);
    idle();
    step();
    chk("t4_post_flush", 64'(flush), 64'd0);
    chk("t4_post_ready_vec", 64'(entry_ready), 64'd0);
    chk("t4_post_tag", 64'(alloc_tag), 64'd0);

    // CDB to a free tag is dropped.
    do_reset();
    cdb_one(6, 32'h6666, 0, 0);
    step();
    chk("t5_empty_ready", 64'(entry_ready), 64'd0);
    for (int i = 0; i < 7; i++) alloc_one(5'(i), 0, 0);
    step();
    chk("t5_alloc_ready_vec", 64'(entry_ready), 64'd0);
    chk("t5_tail", 64'(alloc_tag), 64'd7);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      s_av  = ($urandom_range(0, 9) < 6);
      s_st  = ($urandom_range(0, 4) == 0);
      s_br  = !s_st && ($urandom_range(0, 3) == 0);
      s_rd  = 5'($urandom_range(0, 31));
      s_cv  = ($urandom_range(0, 9) < 7);
      if (rob.size() > 0 && $urandom_range(0, 7) != 0)
        s_ctag = 3'(rob[$urandom_range(0, rob.size() - 1)].tag);
      else
        s_ctag = 3'($urandom_range(0, DEPTH - 1));
      s_cdata = $urandom;
      s_cmp   = ($urandom_range(0, 11) == 0);
      s_ctgt  = $urandom;
      s_resp  = ($urandom_range(0, 2) == 0);
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
